cascade_prescaler: RTL and testbench

//  Parametrised clock-enable divider chain: a PRE_W-bit prescaler produces a tick every
//  pre_lim enabled cycles, feeding NUM_STAGES cascaded STG_W-bit counters with

---
 rtl/cascade_prescaler.sv | 104 ++++++++++
 tb/tb_cascade_prescaler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cascade_prescaler.sv
// Clock-enable divider chain: a prescaler tick drives NUM_STAGES cascaded counters with
// programmable limits, up/down counting, one-shot halt and synchronous clear.
module cascade_prescaler #(
   parameter int PRE_W      = 26,
   parameter int PRE_LIMIT  = 5,
   parameter int NUM_STAGES = 2,
   parameter int STG_W      = 4,
   parameter int STG_LIMIT  = 3,
   localparam int SEL_W     = $clog2(NUM_STAGES+1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        clear,
   input  logic                        count_down,
   input  logic                        oneshot,
   input  logic                        cfg_we,
   input  logic [SEL_W-1:0]            cfg_sel,
   input  logic [PRE_W-1:0]            cfg_data,
   output logic                        pre_tick,
   output logic [NUM_STAGES*STG_W-1:0] cnt,
   output logic                        chain_tc,
   output logic                        done
);

   typedef enum logic {RUN, HALT} state_t;

   state_t                             state_q, state_d;
   logic [PRE_W-1:0]                   pre_cnt_q, pre_cnt_d;
   logic [PRE_W-1:0]                   pre_lim_q, pre_lim_d;
   logic [STG_W-1:0]                   lim_q [NUM_STAGES];
   logic [STG_W-1:0]                   lim_d [NUM_STAGES];
   logic [NUM_STAGES-1:0][STG_W-1:0]   cnt_q, cnt_d;
   logic [NUM_STAGES-1:0]              carry;
   logic [NUM_STAGES-1:0]              wr_stg;
   logic                               run, wr_pre;
   logic [PRE_W-1:0]                   pre_lim_eff;

   assign run         = (state_q == RUN);
   assign wr_pre      = cfg_we && !clear && (cfg_sel == '0);
   assign pre_lim_eff = (pre_lim_q == '0) ? PRE_W'(1) : pre_lim_q;
   assign pre_tick    = !reset && en && run && (pre_cnt_q >= pre_lim_eff - PRE_W'(1));
   assign chain_tc    = !reset && carry[NUM_STAGES-1];
   assign cnt         = cnt_q;
   assign done        = (state_q == HALT);

   always_comb begin
      for (int k = 0; k < NUM_STAGES; k++)
         wr_stg[k] = cfg_we && !clear && (cfg_sel == SEL_W'(k+1));
   end

   always_comb begin
      pre_cnt_d = pre_cnt_q;
      pre_lim_d = pre_lim_q;
      if (clear || wr_pre)   pre_cnt_d = '0;
      else if (pre_tick)     pre_cnt_d = '0;
      else if (en && run)    pre_cnt_d = pre_cnt_q + PRE_W'(1);
      if (wr_pre)            pre_lim_d = cfg_data;
   end

   // Ripple carry is combinational so every stage wraps on the same edge as its source.
   always_comb begin : p_stg
      logic stp;
      logic term;
      stp = pre_tick;
      for (int k = 0; k < NUM_STAGES; k++) begin
         cnt_d[k] = cnt_q[k];
         lim_d[k] = lim_q[k];
         term     = count_down ? (cnt_q[k] == '0) : (cnt_q[k] >= lim_q[k]);
         carry[k] = stp && term && !wr_stg[k];
         if (clear || wr_stg[k])  cnt_d[k] = '0;
         else if (stp) begin
            if (term)             cnt_d[k] = count_down ? lim_q[k] : '0;
            else                  cnt_d[k] = count_down ? cnt_q[k] - STG_W'(1)
                                                        : cnt_q[k] + STG_W'(1);
         end
         if (wr_stg[k])           lim_d[k] = cfg_data[STG_W-1:0];
         stp = carry[k];
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear || cfg_we)                       state_d = RUN;
      else if (run && oneshot && carry[NUM_STAGES-1]) state_d = HALT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RUN;
         pre_cnt_q <= '0;
         pre_lim_q <= PRE_W'(PRE_LIMIT);
         cnt_q     <= '0;
         for (int k = 0; k < NUM_STAGES; k++) lim_q[k] <= STG_W'(STG_LIMIT);
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         pre_lim_q <= pre_lim_d;
         cnt_q     <= cnt_d;
         for (int k = 0; k < NUM_STAGES; k++) lim_q[k] <= lim_d[k];
      end
   end

endmodule

// File: tb/tb_cascade_prescaler.sv
// Directed scenarios for cascade_prescaler; expected outputs per cycle are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_cascade_prescaler;

   logic        clk = 1'b0;
   logic        reset, en, clear, count_down, oneshot, cfg_we;
   logic [1:0]  cfg_sel;
   logic [25:0] cfg_data;
   logic        pre_tick, chain_tc, done;
   logic [7:0]  cnt;

   typedef struct {
      logic       tick;
      logic [7:0] cv;
      logic       tc;
      logic       dn;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   cascade_prescaler dut (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .count_down(count_down),
      .oneshot(oneshot), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .pre_tick(pre_tick), .cnt(cnt), .chain_tc(chain_tc), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("pre_tick", {7'd0, pre_tick}, {7'd0, e.tick});
         chk("cnt",      cnt,              e.cv);
         chk("chain_tc", {7'd0, chain_tc}, {7'd0, e.tc});
         chk("done",     {7'd0, done},     {7'd0, e.dn});
      end
   end

   function automatic logic [7:0] cv(input int s1, input int s0);
      logic [3:0] a, b;
      a = s1[3:0];
      b = s0[3:0];
      return {a, b};
   endfunction

   task automatic step(input bit t, input logic [7:0] c, input bit tc, input bit d);
      exp_t e;
      e.tick = t; e.cv = c; e.tc = tc; e.dn = d;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1; en = 1; clear = 0; count_down = 0; oneshot = 0;
      cfg_we = 0; cfg_sel = '0; cfg_data = '0;
      @(posedge clk); #1;
      step(0, 8'h00, 0, 0);
      reset = 0;
   endtask

   // Default limits, counting up: enabled cycle n counted from 1.
   task automatic run_up(input int n0, input int n1);
      for (int n = n0; n <= n1; n++)
         step(n % 5 == 0, cv(((n-1)/20) % 4, ((n-1)/5) % 4), n % 80 == 0, 0);
   endtask

   initial begin
      reset = 1; en = 0; clear = 0; count_down = 0; oneshot = 0;
      cfg_we = 0; cfg_sel = '0; cfg_data = '0;

      // 1: defaults; an out-of-range cfg_sel write must change nothing
      do_reset();
      cfg_we = 1; cfg_sel = 2'd3; cfg_data = 26'd0;
      step(0, 8'h00, 0, 0);
      cfg_we = 0;
      run_up(2, 165);

      // 2: en low for 33 cycles at cycle 37
      do_reset();
      run_up(1, 36);
      en = 0;
      for (int i = 0; i < 33; i++) step(0, cv(1, 3), 0, 0);
      en = 1;
      run_up(37, 85);

      // 3: stage 0 limit rewritten to 1 while stage 0 = 3
      do_reset();
      run_up(1, 15);
      cfg_we = 1; cfg_sel = 2'd1; cfg_data = 26'd1;
      step(0, cv(0, 3), 0, 0);
      cfg_we = 0;
      for (int n = 17; n <= 60; n++) begin
         int t;
         t = (n-1)/5 - 3;
         step(n % 5 == 0, cv((t/2) % 4, t % 2), (n % 5 == 0) && ((n/5 - 3) % 8 == 0), 0);
      end

      // 4: count down from reset
      do_reset();
      count_down = 1;
      for (int n = 1; n <= 90; n++) begin
         int t, c;
         t = (n-1)/5;
         c = (t+3)/4;
         step(n % 5 == 0, cv((4 - c % 4) % 4, (4 - t % 4) % 4),
              (n % 5 == 0) && (t % 4 == 0) && (c % 4 == 0), 0);
      end

      // 5: one-shot halt, then clear restarts the chain
      do_reset();
      oneshot = 1;
      run_up(1, 80);
      for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 1);
      clear = 1;
      step(0, 8'h00, 0, 1);
      clear = 0;
      run_up(1, 80);
      step(0, 8'h00, 0, 1);
      oneshot = 0;

      // 6: prescaler limit 2, then a one-cycle reset restores limit 5
      do_reset();
      cfg_we = 1; cfg_sel = 2'd0; cfg_data = 26'd2;
      step(0, 8'h00, 0, 0);
      cfg_we = 0;
      for (int m = 1; m <= 36; m++)
         step(m % 2 == 0, cv(((m-1)/8) % 4, ((m-1)/2) % 4), m % 32 == 0, 0);
      reset = 1;
      step(0, cv(0, 2), 0, 0);
      reset = 0;
      run_up(1, 25);

      @(negedge clk); #1;
      chk("queue_drained", 8'(sb.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
